// File: rtl/sample_tick_recovery.sv
// Recovers one-cycle sample enables from the divided sample clock and tracks
// its period, lock state, out-of-tolerance periods and missing ticks.
module sample_tick_recovery #(
  parameter int unsigned CNT_W       = 14,
  parameter int unsigned NOM_PERIOD  = 500,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic             sample_en,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_timeout
);

  localparam int unsigned GC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] GOOD_LO    = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0] GOOD_HI    = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(2 * NOM_PERIOD - 1);
  localparam logic [GC_W-1:0]  LOCK_LAST  = GC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CNT_W-1:0]       cnt, cnt_inc;
  logic [GC_W-1:0]        good_cnt, good_cnt_n;
  logic                   rise, good, timeout;
  logic                   pv_n, err_p_n, err_t_n;

  // cnt_inc doubles as the measured period in the rise cycle (saturating)
  always_comb begin
    rise    = sync[SYNC_STAGES-1] & ~prev;
    cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    good    = (cnt_inc >= GOOD_LO) && (cnt_inc <= GOOD_HI);
    timeout = (cnt == TIMEOUT_AT);
  end

  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    pv_n       = 1'b0;
    err_p_n    = 1'b0;
    err_t_n    = 1'b0;
    case (state)
      SEARCH: begin
        if (rise) begin
          state_n    = ACQUIRE;
          good_cnt_n = '0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          pv_n = 1'b1;
          if (good) begin
            good_cnt_n = good_cnt + GC_W'(1);
            if (good_cnt == LOCK_LAST) state_n = LOCKED;
          end else begin
            err_p_n    = 1'b1;
            good_cnt_n = '0;
          end
        end else if (timeout) begin
          err_t_n    = 1'b1;
          state_n    = SEARCH;
          good_cnt_n = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          pv_n = 1'b1;
          if (!good) begin
            err_p_n    = 1'b1;
            state_n    = ACQUIRE;
            good_cnt_n = '0;
          end
        end else if (timeout) begin
          err_t_n    = 1'b1;
          state_n    = SEARCH;
          good_cnt_n = '0;
        end
      end
      default: begin
        state_n    = SEARCH;
        good_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync         <= '1;
      prev         <= 1'b1;
      cnt          <= '0;
      good_cnt     <= '0;
      state        <= SEARCH;
      sample_en    <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err_period   <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], clk_in};
      prev         <= sync[SYNC_STAGES-1];
      cnt          <= rise ? '0 : cnt_inc;
      good_cnt     <= good_cnt_n;
      state        <= state_n;
      sample_en    <= rise;
      period_valid <= pv_n;
      err_period   <= err_p_n;
      err_timeout  <= err_t_n;
      locked       <= (state == LOCKED);
      if (pv_n) period_out <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_sample_tick_recovery.sv
// Randomised bench for sample_tick_recovery; an edge-indexed event model
// predicts every output on every clock.
module tb_sample_tick_recovery;

  localparam int NOM = 500;
  localparam int TOLR = 2;
  localparam int LOCKN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_in = 1'b1;
  logic        sample_en, period_valid, locked, err_period, err_timeout;
  logic [13:0] period_out;

  int n_checks = 0;
  int n_errors = 0;

  // model state: edge index, sampled clk_in history, tick timing, mode
  int k = 0;
  int last_tick = 0;
  int mode = 0;   // 0 searching, 1 acquiring, 2 locked
  int goods = 0;
  bit h0 = 1, h1 = 1, h2 = 1;
  bit e_se, e_pv, e_ep, e_et, e_lk;
  int e_per = 0;

  sample_tick_recovery #(
    .CNT_W(14), .NOM_PERIOD(NOM), .TOL(TOLR), .LOCK_CNT(LOCKN), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in),
    .sample_en(sample_en), .period_out(period_out), .period_valid(period_valid),
    .locked(locked), .err_period(err_period), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Predicts outputs after edge k from the inputs sampled at that edge.
  task automatic model_step(input bit r, input bit c);
    bit tick;
    int per;
    e_se = 0; e_pv = 0; e_ep = 0; e_et = 0;
    if (r) begin
      h0 = 1; h1 = 1; h2 = 1;
      mode = 0; goods = 0; last_tick = k;
      e_lk = 0; e_per = 0;
    end else begin
      e_lk = (mode == 2);
      tick = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = c;
      if (tick) begin
        e_se = 1;
        per = k - last_tick;
        last_tick = k;
        if (mode == 0) begin
          mode = 1; goods = 0;
        end else begin
          e_pv = 1;
          e_per = per;
          if (per >= NOM - TOLR && per <= NOM + TOLR) begin
            if (mode == 1) begin
              goods++;
              if (goods == LOCKN) mode = 2;
            end
          end else begin
            e_ep = 1; mode = 1; goods = 0;
          end
        end
      end else if (mode != 0 && k - last_tick == 2 * NOM) begin
        e_et = 1; mode = 0; goods = 0;
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    k++;
    model_step(rst, clk_in);
    #1;
    check("sample_en", sample_en, e_se);
    check("period_valid", period_valid, e_pv);
    check("period_out", period_out, e_per);
    check("locked", locked, e_lk);
    check("err_period", err_period, e_ep);
    check("err_timeout", err_timeout, e_et);
  endtask

  task automatic drive_level(input bit v, input int n);
    clk_in = v;
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic drive_period(input int p, input int hi);
    drive_level(1'b1, hi);
    drive_level(1'b0, p - hi);
  endtask

  initial begin
    int p;
    int jit[4] = '{498, 502, 500, 502};

    // reset with clk_in held high, then stay high: no tick expected
    rst = 1'b1; clk_in = 1'b1;
    tick_clk(); tick_clk();
    rst = 1'b0;
    drive_level(1'b1, 100);
    drive_level(1'b0, 10 + $urandom_range(0, 20));

    // nominal 250/250 periods until lock
    for (int i = 0; i < 8; i++) drive_period(NOM, NOM / 2);
    check("nominal_lock", locked, 1);

    // in-tolerance jitter, then random in-tolerance periods
    for (int i = 0; i < 4; i++) drive_period(jit[i], $urandom_range(1, jit[i] - 1));
    for (int i = 0; i < 4; i++) begin
      p = NOM - TOLR + $urandom_range(0, 2 * TOLR);
      drive_period(p, $urandom_range(1, p - 1));
    end
    check("jitter_lock", locked, 1);

    // one bad period while locked, then relock
    drive_period(503, 250);
    for (int i = 0; i < 5; i++) drive_period(NOM, NOM / 2);

    // missing tick: hold low past the timeout, then resume
    drive_level(1'b1, 250);
    drive_level(1'b0, 1100);
    for (int i = 0; i < 7; i++) drive_period(NOM, NOM / 2);
    check("pre_rst_locked", locked, 1);

    // one-cycle reset mid-lock
    drive_level(1'b1, $urandom_range(1, 200));
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    check("post_rst_locked", locked, 0);
    drive_level(1'b1, 20);
    drive_level(1'b0, 20);

    // random periods around nominal, including bad ones
    for (int i = 0; i < 24; i++) begin
      p = $urandom_range(NOM - 6, NOM + 6);
      drive_period(p, $urandom_range(1, p - 1));
    end

    // a late tick landing exactly on the timeout cycle: the rise must win
    for (int i = 0; i < 6; i++) drive_period(NOM, NOM / 2);
    drive_level(1'b1, 10);
    drive_level(1'b0, 2 * NOM - 10);
    drive_period(NOM, NOM / 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_tick_recovery.md
Name: sample_tick_recovery

Overview:
- Receive end of the divided sample-clock interface in the FIR LPF path.
- Takes the 50 %-duty divided clock (nominal 500 system cycles per period, i.e. 20 kHz from 10 MHz), synchronises it and emits one-cycle sample enables in the system clock domain.
- Measures each period and reports lock, bad-period and missing-tick status, so filter stages run on clk plus an enable instead of on a derived clock.

Parameters:
CNT_W, 14, width of period counter and period_out
NOM_PERIOD, 500, expected period in clk cycles
TOL, 2, allowed deviation (cycles) from NOM_PERIOD, inclusive
LOCK_CNT, 4, consecutive good periods required to declare lock
SYNC_STAGES, 2, synchroniser depth on clk_in (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
clk_in  input  1  divided sample clock, treated as asynchronous
sample_en  output  1  one-cycle pulse per detected clk_in rising edge
period_out  output  CNT_W  last measured period in clk cycles
period_valid  output  1  one-cycle pulse when period_out updates
locked  output  1  high while in LOCKED
err_period  output  1  one-cycle pulse on an out-of-tolerance period
err_timeout  output  1  one-cycle pulse on a missing tick

Behaviour:
- Reset: one clock, synchronous, active-high. Applies identically mid-operation; all state is cleared at the next edge.
- Reset values:
  - Synchroniser flops and the edge-detect flop reset to 1, so no rise is reported until clk_in has been seen low after reset.
  - cnt=0, good_cnt=0, state=SEARCH.
  - All outputs 0, period_out=0.
- Edge detect: rise = sync_last & ~prev.
  - sample_en is registered from rise.
  - Latency: clk_in low→high sampled at clk edge n gives sample_en high after edge n+SYNC_STAGES (n+2 by default), for exactly one cycle.
  - sample_en fires on every rise in every state.
- Period counter, every cycle:
  - On rise: cnt<=0, period_out<=cnt+1.
  - Otherwise: cnt<=cnt+1, saturating at all-ones.
  - Rises 500 cycles apart give period_out=500.
- period_valid pulses in the same cycle as sample_en, except on the first rise out of SEARCH. That rise only starts measurement, and period_out is not updated on it.
- good = (NOM_PERIOD-TOL <= cnt+1 <= NOM_PERIOD+TOL), evaluated in the rise cycle.
- Timeout: cnt == 2*NOM_PERIOD-1 with no rise, in ACQUIRE or LOCKED.
  - err_timeout pulses, state<=SEARCH, good_cnt<=0.
  - In SEARCH no timeout is raised.
- State machine:
  - SEARCH, on rise: → ACQUIRE, good_cnt<=0.
  - ACQUIRE, rise with good: good_cnt<=good_cnt+1. If good_cnt+1 == LOCK_CNT → LOCKED.
  - ACQUIRE, rise with bad: err_period pulse, good_cnt<=0, stay in ACQUIRE.
  - LOCKED, rise with good: stay in LOCKED.
  - LOCKED, rise with bad: err_period pulse, → ACQUIRE, good_cnt<=0.
- locked = registered (state==LOCKED). It rises one edge after the rise event that enters LOCKED and falls one edge after an exit event.
- Simultaneous rise and timeout condition: the rise wins (period evaluated, cnt cleared, no err_timeout).
- Saturated cnt: period_out = 2^CNT_W-1 if cnt was saturated (only reachable from SEARCH, where no period is reported).
- err_period and err_timeout are never high in the same cycle.

Test Plan:
- Nominal: clk_in 250 high / 250 low, 8 periods. Expected:
  - sample_en every 500 cycles, 2 edges after each sampled rise.
  - period_out=500 with period_valid on rises 2..8.
  - locked asserts one edge after rise 5; no error pulses.
- Jitter within tolerance, after lock: periods 498, 502, 500, 502. Expected: period_out tracks each value exactly; locked stays 1; err_period never pulses.
- Bad period while LOCKED: one period of 503. Expected:
  - err_period pulse and period_out=503 in the rise cycle.
  - locked drops next edge.
  - 4 further 500-cycle periods: locked reasserts.
- Missing tick while LOCKED: hold clk_in low. Expected:
  - err_timeout pulses when cnt=999 (1000 cycles after the last rise).
  - locked drops; state is SEARCH.
  - Next rise gives sample_en but no period_valid.
- Reset behaviour:
  - Hold clk_in high through rst and for 100 cycles after it. Expected: no sample_en.
  - Drive clk_in low, then high. Expected: first sample_en 2 edges after the high is sampled.
  - Assert rst for 1 cycle mid-LOCKED. Expected: all outputs 0 at the next edge.
